gg_pcm_pack: RTL and testbench
==============================

// Module: gg_pcm_pack
// PURPOSE
//  I_PCM macroblock syntax packer, directly downstream of the PCM buffer.
//  Consumes 24 raster 128-bit PCM beats/MB; emits variable-length symbols (MSB-aligned data + bit length)
//  to the bitstream writer: one header symbol (mb_type ue(v) + pcm_alignment_zero_bits) then 24 sample beats.
// PARAMETERS
//  MB_BEATS  24  sample beats per macroblock (16 luma rows + 8 chroma rows of 16 bytes)
//  LEN_W     8   width of m_len
// PORTS
//  clk        in   1    clock; all logic on rising edge
//  reset      in   1    synchronous, active-high reset
//  slice_p    in   1    1 = P slice (mb_type 30), 0 = I slice (mb_type 25); sampled at MB start
//  bit_align  in   3    writer bit position mod 8 at MB start; sampled with slice_p
//  s_data     in   128  PCM beat, byte 15 (bits 127:120) first in bitstream
//  s_last     in   1    upstream end-of-MB marker
//  s_valid    in   1    AXI-S valid
//  s_ready    out  1    AXI-S ready
//  m_data     out  128  symbol bits, MSB-aligned, unused LSBs zero
//  m_len      out  8    valid bits in m_data (1..128)
//  m_last     out  1    final beat of MB
//  m_valid    out  1    AXI-S valid
//  m_ready    in   1    AXI-S ready
//  err        out  1    sticky: s_last position mismatch seen
// BEHAVIOUR
//  Reset: m_valid=0, m_last=0, m_data=0, m_len=0, s_ready=0, err=0, state=IDLE, beat cnt=0.
//  Output stage is one register (m_*); it loads when empty or when m_valid&&m_ready (full throughput).
//  States:
//   IDLE: s_ready=0. On s_valid=1: latch slice_p, bit_align; load header symbol; -> HDR. s_data not consumed.
//   HDR : header held until m_ready; on accept -> DATA, cnt=0.
//   DATA: s_ready = !m_valid || m_ready. Each s_valid&&s_ready: m_data<=s_data, m_len<=128, cnt++.
//         Beat cnt==MB_BEATS-1: m_last<=1; -> IDLE once that beat is accepted downstream.
//  Header symbol: I: 9'b0_0001_1010; P: 9'b0_0001_1111; at m_data[127:119]; rest zero.
//   m_len = 16 - bit_align (9 header bits + (7-bit_align) zero pad) -> range 9..16; ends byte-aligned.
//  Latency: header 1 cycle after s_valid seen in IDLE; sample beats 1 cycle input->output.
//  MB framing set by own counter only. s_last on beat != MB_BEATS-1, or absent on beat MB_BEATS-1,
//   sets err (sticky until reset); beat still forwarded, framing unchanged.
//  Backpressure: m_* stable while m_valid && !m_ready; s_ready=0 in that case.
//  Back-to-back MBs: IDLE lasts 1 cycle minimum between MBs (header re-sampled per MB).
//  Reset mid-MB: all state cleared, partial MB discarded; next s_valid starts a new header.
// CONFIGURATION
//  GG_PCM_ZERO_CLAMP_EN defined: every sample byte 0x00 replaced by 0x01 on the data path
//   (legacy-profile pcm_sample restriction); header unaffected.
//  Undefined: sample bytes passed bit-exact.
// TESTING
//  I slice, bit_align=0, 24 beats byte=k -> hdr m_data[127:112]=16'h0D00, m_len=16; then 24 beats m_len=128, m_last on 24th.
//  P slice, bit_align=7 -> hdr m_data[127:119]=9'h01F, m_len=9, lower bits 0.
//  Random m_ready (50%) over 4 MBs -> no beat lost/duplicated; m_* stable while stalled; data order intact.
//  s_last on beat 23 (of 0..23 -> 22) -> err=1, m_last still only on 24th beat; reset clears err.
//  Reset asserted at beat 10 -> m_valid=0 next cycle; next MB emits header first, full 24 beats.
//  With GG_PCM_ZERO_CLAMP_EN: beat all 0x00 -> output all 0x01; without: output all 0x00.

Source files
------------

// File: rtl/gg_pcm_pack.sv
// gg_pcm_pack: I_PCM macroblock syntax packer.
// Per macroblock: one header symbol (mb_type ue(v) + alignment pad) followed by
// MB_BEATS raw 128-bit sample beats, each emitted as an MSB-aligned symbol with bit length.
// Optional build macro: GG_PCM_ZERO_CLAMP_EN (replace sample bytes 0x00 by 0x01).
//
// state | meaning
// IDLE  | waiting for first beat of a macroblock; header is built from slice_p/bit_align
// HDR   | header symbol held in the output register until accepted downstream
// DATA  | forwarding sample beats; returns to IDLE when the m_last beat is accepted
module gg_pcm_pack #(
    parameter int MB_BEATS = 24,
    parameter int LEN_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             slice_p,
    input  logic [2:0]       bit_align,
    input  logic [127:0]     s_data,
    input  logic             s_last,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [127:0]     m_data,
    output logic [LEN_W-1:0] m_len,
    output logic             m_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             err
);

    // cnt counts beats loaded this MB; reaching MB_BEATS blocks further input
    localparam int CNT_W = $clog2(MB_BEATS + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             out_free;
    logic             last_beat;
    logic [8:0]       hdr_bits;
    logic [127:0]     sample;

    assign out_free  = !m_valid || m_ready;
    assign last_beat = (cnt == CNT_W'(MB_BEATS - 1));
    assign s_ready   = (state == DATA) && (cnt != CNT_W'(MB_BEATS)) && out_free;
    // ue(v) of mb_type: 25 -> 000011010, 30 -> 000011111
    assign hdr_bits  = slice_p ? 9'b0_0001_1111 : 9'b0_0001_1010;

    // Sample data path, optionally clamping zero bytes
    always_comb begin
        sample = s_data;
`ifdef GG_PCM_ZERO_CLAMP_EN
        for (int b = 0; b < 16; b++) begin
            if (s_data[b*8 +: 8] == 8'h00) begin
                sample[b*8 +: 8] = 8'h01;
            end
        end
`endif
    end

    // Framing FSM and registered output stage
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            m_data  <= '0;
            m_len   <= '0;
            m_last  <= 1'b0;
            m_valid <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (s_valid && !m_valid) begin
                        // header pad ends byte-aligned: 9 bits + (7 - bit_align) zeros
                        m_data  <= {hdr_bits, 119'b0};
                        m_len   <= LEN_W'(5'd16 - {2'b00, bit_align});
                        m_last  <= 1'b0;
                        m_valid <= 1'b1;
                        state   <= HDR;
                    end
                end
                HDR: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        cnt     <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (s_valid && s_ready) begin
                        m_data  <= sample;
                        m_len   <= LEN_W'(128);
                        m_last  <= last_beat;
                        m_valid <= 1'b1;
                        cnt     <= cnt + 1'b1;
                        // framing follows cnt only; a misplaced s_last is just flagged
                        if (s_last != last_beat) begin
                            err <= 1'b1;
                        end
                    end else if (m_valid && m_ready) begin
                        m_valid <= 1'b0;
                        m_last  <= 1'b0;
                        if (m_last) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gg_pcm_pack.sv
// Testbench for gg_pcm_pack: table of macroblock runs plus reset corner sequences.
module tb_gg_pcm_pack;

    localparam int MB = 24;

    logic         clk = 1'b0;
    logic         reset;
    logic         slice_p;
    logic [2:0]   bit_align;
    logic [127:0] s_data;
    logic         s_last;
    logic         s_valid;
    logic         s_ready;
    logic [127:0] m_data;
    logic [7:0]   m_len;
    logic         m_last;
    logic         m_valid;
    logic         m_ready;
    logic         err;

    int checks = 0;
    int errors = 0;

    gg_pcm_pack #(.MB_BEATS(MB), .LEN_W(8)) dut (
        .clk(clk), .reset(reset), .slice_p(slice_p), .bit_align(bit_align),
        .s_data(s_data), .s_last(s_last), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_len(m_len), .m_last(m_last), .m_valid(m_valid),
        .m_ready(m_ready), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       sp;
        logic [2:0] ba;
        logic [7:0] base;
        int         pct;
        int         last_pos;
        logic [15:0] exp_top;
        logic [7:0]  exp_len;
        logic        exp_err;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] raw_beat(input logic [7:0] base, input int i);
        logic [7:0] b;
        b = base + 8'(i);
        return {16{b}};
    endfunction

    function automatic logic [127:0] exp_beat(input logic [7:0] base, input int i);
        logic [7:0] b;
        b = base + 8'(i);
`ifdef GG_PCM_ZERO_CLAMP_EN
        if (b == 8'h00) b = 8'h01;
`endif
        return {16{b}};
    endfunction

    // Producer: presents beats 0..MB-1, returns early (s_valid still high) at stop_at
    task automatic send(input logic sp, input logic [2:0] ba, input logic [7:0] base,
                        input int last_pos, input int stop_at);
        int t;
        @(negedge clk);
        for (int i = 0; i < MB; i++) begin
            if (i == stop_at) return;
            slice_p   = sp;
            bit_align = ba;
            s_valid   = 1'b1;
            s_data    = raw_beat(base, i);
            s_last    = (i == last_pos);
            t = 0;
            forever begin
                #2;
                if (s_ready) break;
                @(negedge clk);
                t++;
                if (t > 400) begin
                    checks++;
                    errors++;
                    $display("FAIL send_timeout: beat %0d not accepted", i);
                    s_valid = 1'b0;
                    return;
                end
            end
            @(negedge clk);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // Consumer: header then MB beats, checks content and stall stability
    task automatic recv(input logic [15:0] exp_top, input logic [7:0] exp_len,
                        input logic [7:0] base, input int pct);
        logic [127:0] hd;
        logic [7:0]   hl;
        logic         hlast;
        logic         held;
        int           t;
        held = 1'b0;
        hd = '0;
        hl = '0;
        hlast = 1'b0;
        for (int n = 0; n <= MB; n++) begin
            t = 0;
            forever begin
                @(negedge clk);
                m_ready = (pct >= 100) ? 1'b1 : 1'($urandom_range(0, 1));
                #2;
                if (held) begin
                    check("stall_valid", 128'(m_valid), 128'(1));
                    check("stall_data", m_data, hd);
                    check("stall_len", 128'(m_len), 128'(hl));
                    check("stall_last", 128'(m_last), 128'(hlast));
                    held = 1'b0;
                end
                if (m_valid && m_ready) begin
                    if (n == 0) begin
                        check("hdr_top16", 128'(m_data[127:112]), 128'(exp_top));
                        check("hdr_low_zero", 128'(m_data[111:0]), 128'(0));
                        check("hdr_len", 128'(m_len), 128'(exp_len));
                        check("hdr_last", 128'(m_last), 128'(0));
                    end else begin
                        check("beat_data", m_data, exp_beat(base, n - 1));
                        check("beat_len", 128'(m_len), 128'(128));
                        check("beat_last", 128'(m_last), 128'(n == MB));
                    end
                    break;
                end
                if (m_valid) begin
                    hd = m_data;
                    hl = m_len;
                    hlast = m_last;
                    held = 1'b1;
                end
                t++;
                if (t > 400) begin
                    checks++;
                    errors++;
                    $display("FAIL recv_timeout: symbol %0d not seen", n);
                    return;
                end
            end
        end
    endtask

    initial begin
        //          sp    ba    base   pct last exp_top  len  err
        vecs[0] = '{1'b0, 3'd0, 8'h00, 100, 23, 16'h0D00, 8'd16, 1'b0};
        vecs[1] = '{1'b1, 3'd7, 8'h40, 100, 23, 16'h0F80, 8'd9,  1'b0};
        vecs[2] = '{1'b0, 3'd3, 8'h80, 50,  23, 16'h0D00, 8'd13, 1'b0};
        vecs[3] = '{1'b1, 3'd0, 8'h10, 50,  23, 16'h0F80, 8'd16, 1'b0};
        vecs[4] = '{1'b0, 3'd5, 8'h20, 50,  23, 16'h0D00, 8'd11, 1'b0};
        vecs[5] = '{1'b1, 3'd2, 8'h30, 50,  23, 16'h0F80, 8'd14, 1'b0};
        vecs[6] = '{1'b0, 3'd1, 8'h50, 100, 22, 16'h0D00, 8'd15, 1'b1};

        reset = 1'b1;
        slice_p = 1'b0;
        bit_align = 3'd0;
        s_data = '0;
        s_last = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_m_valid", 128'(m_valid), 128'(0));
        check("rst_m_last", 128'(m_last), 128'(0));
        check("rst_m_data", m_data, 128'(0));
        check("rst_m_len", 128'(m_len), 128'(0));
        check("rst_s_ready", 128'(s_ready), 128'(0));
        check("rst_err", 128'(err), 128'(0));
        reset = 1'b0;

        for (int v = 0; v < 7; v++) begin
            fork
                send(vecs[v].sp, vecs[v].ba, vecs[v].base, vecs[v].last_pos, MB);
                recv(vecs[v].exp_top, vecs[v].exp_len, vecs[v].base, vecs[v].pct);
            join
            @(negedge clk);
            #2;
            check("idle_gap_m_valid", 128'(m_valid), 128'(0));
            check("err_flag", 128'(err), 128'(vecs[v].exp_err));
        end

        // reset clears sticky err
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("err_cleared", 128'(err), 128'(0));
        reset = 1'b0;

        // reset in the middle of an MB, after 10 beats accepted
        m_ready = 1'b1;
        send(1'b0, 3'd0, 8'h60, 23, 10);
        reset = 1'b1;
        s_valid = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_m_valid", 128'(m_valid), 128'(0));
        check("midrst_s_ready", 128'(s_ready), 128'(0));
        check("midrst_m_last", 128'(m_last), 128'(0));
        @(negedge clk);
        reset = 1'b0;
        fork
            send(1'b1, 3'd4, 8'h60, 23, MB);
            recv(16'h0F80, 8'd12, 8'h60, 100);
        join
        @(negedge clk);
        #2;
        check("post_rst_err", 128'(err), 128'(0));
        check("post_rst_idle", 128'(m_valid), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
